// File: rtl/pulse_period_meter_pkg.sv
// Shared definitions for the periodic-pulse receive logic: FSM state
// encodings reused by the pulse blocks.
package pulse_period_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_MEAS = 2'd2
   } state_t;

endpackage

// File: rtl/pulse_period_meter.sv
// Periodic-pulse receive side: measures the clk-cycle spacing of a strobe
// train, hands each period out over valid/ready, and flags lost pulses
// (timeout) and results overwritten before they were consumed (overrun).
module pulse_period_meter
   import pulse_period_meter_pkg::*;
#(
   parameter int NBITS   = 16,
   parameter int TIMEOUT = 50000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             pulse_in,
   output logic [NBITS-1:0] period,
   output logic             period_valid,
   input  logic             period_ready,
   output logic             timeout,
   output logic             overrun,
   output logic             locked
);

   // An unusable TIMEOUT would either never fire or never be reachable.
   generate
      if ((TIMEOUT < 1) ||
          (longint'(TIMEOUT) > ((longint'(1) << NBITS) - longint'(1)))) begin : g_bad_timeout
         $error("pulse_period_meter: TIMEOUT must be in 1 .. 2**NBITS-1");
      end
   endgenerate

   localparam logic [NBITS-1:0] TIMEOUT_V = NBITS'(TIMEOUT);
   localparam logic [NBITS-1:0] CNT_ONE   = NBITS'(1);

   state_t           state;
   logic [NBITS-1:0] cnt;
   logic             new_result;
   logic             accept;
   logic             cnt_expired;

   // Decode which of result / transfer / timeout happens this cycle.
   always_comb begin
      new_result  = 1'b0;
      accept      = 1'b0;
      cnt_expired = 1'b0;
      if (enable && (state == ST_MEAS) && pulse_in) begin
         new_result = 1'b1;
      end else begin
         new_result = 1'b0;
      end
      if (period_valid && period_ready) begin
         accept = 1'b1;
      end else begin
         accept = 1'b0;
      end
      if (enable && (state == ST_MEAS) && !pulse_in && (cnt == TIMEOUT_V)) begin
         cnt_expired = 1'b1;
      end else begin
         cnt_expired = 1'b0;
      end
   end

   // FSM, period counter, result register and status flags; all outputs registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         timeout      <= 1'b0;
         overrun      <= 1'b0;
         locked       <= 1'b0;
      end else if (!enable) begin
         // Period is deliberately kept so the last result stays readable.
         state        <= ST_IDLE;
         cnt          <= '0;
         period_valid <= 1'b0;
         timeout      <= 1'b0;
         overrun      <= 1'b0;
         locked       <= 1'b0;
      end else begin
         timeout <= cnt_expired;

         case (state)
            ST_IDLE: begin
               // Events on the cycle enable rises are not counted.
               state <= ST_ARM;
               cnt   <= '0;
            end
            ST_ARM: begin
               if (pulse_in) begin
                  state <= ST_MEAS;
                  cnt   <= CNT_ONE;
               end else begin
                  state <= ST_ARM;
               end
            end
            ST_MEAS: begin
               if (pulse_in) begin
                  cnt <= CNT_ONE;
               end else if (cnt_expired) begin
                  state  <= ST_ARM;
                  cnt    <= '0;
                  locked <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase

         // A landing result wins over a same-cycle transfer, so valid stays up.
         if (new_result) begin
            period       <= cnt;
            period_valid <= 1'b1;
            locked       <= 1'b1;
            if (period_valid && !period_ready) begin
               overrun <= 1'b1;
            end else begin
               overrun <= overrun;
            end
         end else if (accept) begin
            period_valid <= 1'b0;
         end else begin
            period_valid <= period_valid;
         end
      end
   end

endmodule
